// File: rtl/video_stream_crc_sink.sv
// AXI-Stream pixel sink: checks frame geometry, computes a per-frame CRC-32 and
// counts frames/beats/drops, with optional LFSR-driven tready throttling.
module video_stream_crc_sink #(
    parameter int          WIDTH     = 32,
    parameter int          HEIGHT    = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    input  logic        stall_en,
    input  logic        err_clr,
    input  logic [31:0] golden_crc,
    output logic [31:0] frame_count,
    output logic [31:0] crc_last,
    output logic        crc_ok,
    output logic [31:0] beat_count,
    output logic [15:0] drop_count,
    output logic [15:0] line_count,
    output logic [15:0] pixel_in_line,
    output logic [3:0]  err_flags,
    output logic        frame_done
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    localparam logic [15:0] LAST_X   = 16'(WIDTH - 1);
    localparam logic [15:0] LAST_Y   = 16'(HEIGHT - 1);
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Non-reflected CRC-32, pixel shifted in MSB first.
    function automatic logic [31:0] crcFold(input logic [31:0] crcIn, input logic [23:0] pix);
        logic [31:0] c;
        logic        fb;
        c = crcIn;
        for (int i = 23; i >= 0; i--) begin
            fb = c[31] ^ pix[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        tready_q, tready_d;
    logic [31:0] crcRun_q, crcRun_d;
    logic [31:0] crcLast_q, crcLast_d;
    logic [31:0] frameCount_q, frameCount_d;
    logic [31:0] beatCount_q, beatCount_d;
    logic [15:0] dropCount_q, dropCount_d;
    logic [15:0] lineCount_q, lineCount_d;
    logic [15:0] pixelIdx_q, pixelIdx_d;
    logic [3:0]  err_q, err_d;
    logic        frameDone_q, frameDone_d;

    logic        accept;
    logic        lfsrFb;
    logic [31:0] foldSof;
    logic [31:0] foldRun;
    logic [3:0]  newErr;

    assign accept  = s_axis_tvalid && tready_q;
    assign lfsrFb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign foldSof = crcFold(CRC_INIT, s_axis_tdata);
    assign foldRun = crcFold(crcRun_q, s_axis_tdata);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[14:0], lfsrFb};
        tready_d     = stall_en ? (lfsr_q[0] | lfsr_q[1]) : 1'b1;
        crcRun_d     = crcRun_q;
        crcLast_d    = crcLast_q;
        frameCount_d = frameCount_q;
        beatCount_d  = beatCount_q;
        dropCount_d  = dropCount_q;
        lineCount_d  = lineCount_q;
        pixelIdx_d   = pixelIdx_q;
        frameDone_d  = 1'b0;
        newErr       = 4'b0000;

        if (accept) begin
            beatCount_d = beatCount_q + 32'd1;
            // A SOF always restarts the frame; a SOF that also carries tlast is a one-pixel short line.
            if (s_axis_tuser) begin
                if (state_q == ACTIVE) begin
                    newErr[2] = 1'b1;
                end
                if (s_axis_tlast) begin
                    newErr[0]   = 1'b1;
                    state_d     = IDLE;
                    pixelIdx_d  = 16'd0;
                    lineCount_d = 16'd0;
                end else begin
                    state_d     = ACTIVE;
                    crcRun_d    = foldSof;
                    pixelIdx_d  = 16'd1;
                    lineCount_d = 16'd0;
                end
            end else if (state_q == IDLE) begin
                if (dropCount_q != 16'hFFFF) begin
                    dropCount_d = dropCount_q + 16'd1;
                end
            end else if (s_axis_tlast && (pixelIdx_q != LAST_X)) begin
                newErr[0]   = 1'b1;
                state_d     = IDLE;
                pixelIdx_d  = 16'd0;
                lineCount_d = 16'd0;
            end else if ((pixelIdx_q == LAST_X) && !s_axis_tlast) begin
                newErr[1]   = 1'b1;
                state_d     = IDLE;
                pixelIdx_d  = 16'd0;
                lineCount_d = 16'd0;
            end else if (pixelIdx_q == LAST_X) begin
                crcRun_d   = foldRun;
                pixelIdx_d = 16'd0;
                if (lineCount_q != LAST_Y) begin
                    lineCount_d = lineCount_q + 16'd1;
                end else begin
                    crcLast_d    = foldRun ^ CRC_INIT;
                    frameCount_d = frameCount_q + 32'd1;
                    frameDone_d  = 1'b1;
                    lineCount_d  = 16'd0;
                    state_d      = IDLE;
                end
            end else begin
                crcRun_d   = foldRun;
                pixelIdx_d = pixelIdx_q + 16'd1;
            end
        end

        // A clear in the same cycle as a new error keeps the new error.
        err_d    = (err_q & {4{~err_clr}}) | newErr;
        err_d[3] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            tready_q     <= 1'b0;
            crcRun_q     <= 32'd0;
            crcLast_q    <= 32'd0;
            frameCount_q <= 32'd0;
            beatCount_q  <= 32'd0;
            dropCount_q  <= 16'd0;
            lineCount_q  <= 16'd0;
            pixelIdx_q   <= 16'd0;
            err_q        <= 4'd0;
            frameDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            tready_q     <= tready_d;
            crcRun_q     <= crcRun_d;
            crcLast_q    <= crcLast_d;
            frameCount_q <= frameCount_d;
            beatCount_q  <= beatCount_d;
            dropCount_q  <= dropCount_d;
            lineCount_q  <= lineCount_d;
            pixelIdx_q   <= pixelIdx_d;
            err_q        <= err_d;
            frameDone_q  <= frameDone_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign frame_count   = frameCount_q;
    assign crc_last      = crcLast_q;
    assign crc_ok        = (crcLast_q == golden_crc) && (frameCount_q != 32'd0);
    assign beat_count    = beatCount_q;
    assign drop_count    = dropCount_q;
    assign line_count    = lineCount_q;
    assign pixel_in_line = pixelIdx_q;
    assign err_flags     = err_q;
    assign frame_done    = frameDone_q;

endmodule

// File: tb/tb_video_stream_crc_sink.sv
// Bench for video_stream_crc_sink: directed frames with a frame_done scoreboard
// and direct checks of counters and error flags.
module tb_video_stream_crc_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tready;
    logic        stall_en = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] golden_crc = '0;
    logic [31:0] frame_count;
    logic [31:0] crc_last;
    logic        crc_ok;
    logic [31:0] beat_count;
    logic [15:0] drop_count;
    logic [15:0] line_count;
    logic [15:0] pixel_in_line;
    logic [3:0]  err_flags;
    logic        frame_done;

    typedef struct {
        int          frameNo;
        logic [31:0] crc;
    } expT;

    expT         sbQ[$];
    int          checks = 0;
    int          errors = 0;
    int          donePulses = 0;
    int          readyLow = 0;
    logic [31:0] cleanCrc;

    video_stream_crc_sink #(.WIDTH(32), .HEIGHT(24), .LFSR_SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .stall_en     (stall_en),
        .err_clr      (err_clr),
        .golden_crc   (golden_crc),
        .frame_count  (frame_count),
        .crc_last     (crc_last),
        .crc_ok       (crc_ok),
        .beat_count   (beat_count),
        .drop_count   (drop_count),
        .line_count   (line_count),
        .pixel_in_line(pixel_in_line),
        .err_flags    (err_flags),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelFold(input logic [31:0] crcIn, input logic [23:0] pix);
        logic [31:0] c;
        c = crcIn;
        for (int i = 23; i >= 0; i--) begin
            if (c[31] ^ pix[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
            else                c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Holds the beat until it is accepted; tready is sampled between edges.
    task automatic applyStimulus(input logic [23:0] data, input logic user, input logic last);
        logic ready;
        int   waitCycles;
        waitCycles    = 0;
        s_axis_tdata  = data;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        do begin
            ready = s_axis_tready;
            @(posedge clk);
            #1;
            waitCycles++;
        end while (!ready && waitCycles < 64);
        if (!ready) checkOutput("tready_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendSeq(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(24'(i), i == 0, (i % 32) == 31);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        idleCycles(1);
        err_clr = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("rst_frame_count", frame_count, 32'd0);
        checkOutput("rst_crc_last", crc_last, 32'd0);
        checkOutput("rst_beat_count", beat_count, 32'd0);
        checkOutput("rst_misc", {drop_count, line_count}, 32'd0);
        checkOutput("rst_flags", {pixel_in_line, 4'd0, err_flags, 6'd0, crc_ok, frame_done}, 32'd0);
        idleCycles(3);
        rst_n = 1'b1;
        idleCycles(2);
    endtask

    always @(negedge clk) begin
        if (rst_n && !s_axis_tready) readyLow++;
    end

    always @(negedge clk) begin
        expT e;
        if (rst_n && frame_done) begin
            donePulses++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_frame_count", frame_count, 32'(e.frameNo));
                checkOutput("sb_crc_last", crc_last, e.crc);
            end
        end
    end

    initial begin
        cleanCrc = 32'hFFFFFFFF;
        for (int i = 0; i < 768; i++) cleanCrc = modelFold(cleanCrc, 24'(i));
        cleanCrc = cleanCrc ^ 32'hFFFFFFFF;

        applyReset();
        checkOutput("tready_after_release", 32'(s_axis_tready), 32'd1);

        // Unsynchronised beats are dropped.
        readyLow = 0;
        for (int i = 0; i < 100; i++) applyStimulus(24'(i), 1'b0, (i % 32) == 31);
        s_axis_tvalid = 1'b0;
        idleCycles(2);
        checkOutput("drop_count", 32'(drop_count), 32'd100);
        checkOutput("drop_beat_count", beat_count, 32'd100);
        checkOutput("drop_frame_count", frame_count, 32'd0);
        checkOutput("drop_ready_low", 32'(readyLow), 32'd0);

        applyReset();
        donePulses = 0;
        sbQ.push_back('{1, cleanCrc});
        sendSeq(768);
        idleCycles(3);
        checkOutput("clean_beat_count", beat_count, 32'd768);
        checkOutput("clean_done_pulses", 32'(donePulses), 32'd1);
        checkOutput("clean_err_flags", 32'(err_flags), 32'd0);
        checkOutput("clean_frame_count", frame_count, 32'd1);

        sbQ.push_back('{2, cleanCrc});
        sendSeq(768);
        idleCycles(3);
        checkOutput("clean2_beat_count", beat_count, 32'd1536);

        // Short line at x=15 of line 3.
        sendSeq(111);
        applyStimulus(24'd111, 1'b0, 1'b1);
        s_axis_tvalid = 1'b0;
        idleCycles(2);
        checkOutput("short_err_flags", 32'(err_flags), 32'h1);
        checkOutput("short_frame_count", frame_count, 32'd2);
        checkOutput("short_pos", {line_count, pixel_in_line}, 32'd0);
        checkOutput("short_beat_count", beat_count, 32'd1648);
        applyStimulus(24'd7, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        idleCycles(1);
        checkOutput("short_idle_drop", 32'(drop_count), 32'd1);
        pulseErrClr();
        checkOutput("errclr_flags", 32'(err_flags), 32'd0);
        sbQ.push_back('{3, cleanCrc});
        sendSeq(768);
        idleCycles(3);
        checkOutput("recover_err_flags", 32'(err_flags), 32'd0);
        checkOutput("recover_beat_count", beat_count, 32'd2417);

        // Early SOF at line 10, x=5, then a full frame from that beat.
        sendSeq(325);
        sbQ.push_back('{4, cleanCrc});
        sendSeq(768);
        idleCycles(3);
        checkOutput("early_sof_err_flags", 32'(err_flags), 32'h4);
        checkOutput("early_sof_frame_count", frame_count, 32'd4);

        // Long line with err_clr on the same beat: new bit set, old bit cleared.
        sendSeq(31);
        err_clr = 1'b1;
        applyStimulus(24'd31, 1'b0, 1'b0);
        err_clr = 1'b0;
        s_axis_tvalid = 1'b0;
        idleCycles(2);
        checkOutput("long_err_flags", 32'(err_flags), 32'h2);
        checkOutput("long_frame_count", frame_count, 32'd4);

        pulseErrClr();
        sendSeq(3);
        applyStimulus(24'd0, 1'b1, 1'b1);
        s_axis_tvalid = 1'b0;
        idleCycles(2);
        checkOutput("sof_tlast_err_flags", 32'(err_flags), 32'h5);
        checkOutput("sof_tlast_pos", {line_count, pixel_in_line}, 32'd0);

        // Throttled tready.
        applyReset();
        stall_en = 1'b1;
        readyLow = 0;
        sbQ.push_back('{1, cleanCrc});
        sendSeq(768);
        idleCycles(3);
        stall_en = 1'b0;
        checkOutput("stall_ready_low_seen", 32'(readyLow > 0), 32'd1);
        checkOutput("stall_beat_count", beat_count, 32'd768);
        checkOutput("stall_crc_ok_unset", 32'(crc_ok), 32'd0);
        golden_crc = cleanCrc;
        #1;
        checkOutput("stall_crc_ok", 32'(crc_ok), 32'd1);
        golden_crc = cleanCrc ^ 32'h1;
        #1;
        checkOutput("crc_ok_wrong_golden", 32'(crc_ok), 32'd0);
        golden_crc = cleanCrc;
        idleCycles(2);

        // Mid-frame async reset.
        sendSeq(300);
        checkOutput("mid_pos", {line_count, pixel_in_line}, {16'd9, 16'd12});
        applyReset();
        sbQ.push_back('{1, cleanCrc});
        sendSeq(768);
        idleCycles(3);
        checkOutput("post_reset_frame_count", frame_count, 32'd1);
        checkOutput("post_reset_beat_count", beat_count, 32'd768);
        checkOutput("post_reset_crc_ok", 32'(crc_ok), 32'd1);

        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_stream_crc_sink.md
Name: video_stream_crc_sink

Overview:
- Receiving end of the pixel AXI-Stream produced by the voxel render shell.
- Accepts 24-bit RGB beats framed by tuser (start of frame) and tlast (end of line), checks them against the configured geometry, and computes a per-frame CRC-32.
- Exposes frame, line and beat counters plus sticky framing-error flags, and can throttle tready to exercise producer backpressure.
- Used in RTL benches and as an on-chip capture/check monitor ahead of the HDMI PHY.

Parameters:
- WIDTH, 32, active pixels per line (≥2).
- HEIGHT, 24, active lines per frame (≥1).
- LFSR_SEED, 16'hACE1, reset seed of the 16-bit throttle LFSR (nonzero).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  24  pixel {R,G,B}.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last pixel of line.
- s_axis_tuser  in  1  first pixel of frame.
- s_axis_tready  out  1  sink ready (registered).
- stall_en  in  1  enable pseudo-random tready throttling.
- err_clr  in  1  clear err_flags (single-cycle pulse).
- golden_crc  in  32  expected frame CRC.
- frame_count  out  32  good frames completed.
- crc_last  out  32  CRC of the last good frame.
- crc_ok  out  1  crc_last == golden_crc and frame_count != 0.
- beat_count  out  32  total accepted beats.
- drop_count  out  16  beats discarded while unsynchronised (saturating).
- line_count  out  16  current line index within frame.
- pixel_in_line  out  16  current pixel index within line.
- err_flags  out  4  sticky: [0] short line, [1] long line, [2] early SOF, [3] reserved (0).
- frame_done  out  1  one-cycle pulse when a good frame completes.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including s_axis_tready; LFSR = LFSR_SEED; state = IDLE. Mid-frame reset abandons the frame with no count or CRC update.
- Accept: a beat is accepted iff s_axis_tvalid && s_axis_tready on a rising edge. Non-accepted cycles change no state except the LFSR.
- tready:
  - Registered.
  - stall_en=0: 1 from the first edge after reset release.
  - stall_en=1: next tready = LFSR[0] | LFSR[1] (~75% duty).
  - LFSR is Fibonacci, taps 16,14,13,11, and advances every cycle.
- CRC:
  - Polynomial 0x04C11DB7, non-reflected.
  - Each accepted pixel folds in 24 bits MSB first (tdata[23] first).
  - Running value is initialised to 0xFFFFFFFF on each SOF beat before that beat is folded.
  - crc_last = running ^ 0xFFFFFFFF.
  - All counters are modulo 2^width, except drop_count, which saturates.
- IDLE:
  - Accepted beat with tuser=0: drop_count++ and the beat is discarded.
  - Accepted beat with tuser=1: go to ACTIVE, CRC init+fold, pixel_in_line=1, line_count=0.
- ACTIVE (x = pixel_in_line, y = line_count, per accepted beat):
  - tuser=1: err_flags[2]=1; the beat is treated as the SOF of a new frame, same as the IDLE SOF case.
  - tlast=1 with x<WIDTH-1: err_flags[0]=1; go to IDLE; frame discarded.
  - x==WIDTH-1 with tlast=0: err_flags[1]=1; go to IDLE; frame discarded.
  - x==WIDTH-1 with tlast=1 and y<HEIGHT-1: fold pixel, x=0, y++.
  - x==WIDTH-1 with tlast=1 and y==HEIGHT-1: fold pixel; crc_last and frame_count++ update at that edge; frame_done=1 for the following cycle; x=y=0; go to IDLE.
  - Any other beat: fold pixel, x++.
- beat_count increments on every accepted beat in any state.
- tuser and tlast on the same ACTIVE beat: the SOF restart applies first; the resulting short line then sets err_flags[0] and the state goes to IDLE.
- err_clr in the same cycle as a new error: the error bit is set (set wins); other bits clear.
- crc_ok is combinational from crc_last, golden_crc and frame_count.

Test Plan:
- Clean 32x24 frame, stall_en=0, incrementing pixel data:
  - after the frame: frame_count=1, beat_count=768, frame_done pulsed once, err_flags=0, crc_last equals the bench software model;
  - a second identical frame gives frame_count=2 and the same crc_last.
- tlast at x=15 of line 3: err_flags=4'b0001, frame_count unchanged, state IDLE. Then err_clr, then a clean frame: frame_count+1, crc_last same as the clean-frame value, err_flags=0.
- tuser asserted at line 10, x=5, followed by a full 768-beat frame from that beat: err_flags[2]=1, frame_count+1, crc_last equals the clean-frame CRC.
- 100 beats with tuser=0 after reset: drop_count=100, beat_count=100, frame_count=0, tready continuously 1.
- stall_en=1, producer holds tvalid with stable data: tready low in some cycles; beats held through low-tready cycles are not counted twice; beat_count=768; crc_last equals the stall_en=0 result. Set golden_crc to that value: crc_ok=1.
- Assert rst_n=0 after 300 accepted beats: all outputs 0 immediately (async). After release, a clean frame gives frame_count=1 and the clean-frame CRC.
